// File: rtl/fetch_refill_arbiter_pkg.sv
// ============================================================================
// Module  : fetch_refill_arbiter_pkg
// Purpose : FSM state type and line-geometry helpers for the refill arbiter.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package fetch_refill_arbiter_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQUEST = 3'd1,
    S_COLLECT = 3'd2,
    S_DELIVER = 3'd3,
    S_DRAIN   = 3'd4
  } state_e;

  // Byte-offset bits inside one line of 32-bit words.
  function automatic int line_off_w(input int line_words);
    return $clog2(line_words * 4);
  endfunction

  function automatic int beat_cnt_w(input int line_words);
    return $clog2(line_words);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_refill_arbiter.sv
// ============================================================================
// Module  : fetch_refill_arbiter
// Purpose : Two-port cache refill arbiter: one line fetch at a time, with flush.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module fetch_refill_arbiter
  import fetch_refill_arbiter_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int LINE_WORDS = 4
) (
  input  logic                    clock_i,
  input  logic                    reset_i,
  input  logic [1:0]              miss_req_i,
  input  logic [2*XLEN-1:0]       miss_addr_i,
  input  logic                    flush_i,
  output logic                    mem_req_o,
  output logic [XLEN-1:0]         mem_addr_o,
  input  logic                    mem_ack_i,
  input  logic                    mem_data_valid_i,
  input  logic [31:0]             mem_data_i,
  output logic [1:0]              refill_valid_o,
  output logic [XLEN-1:0]         refill_addr_o,
  output logic [32*LINE_WORDS-1:0] refill_line_o,
  output logic                    busy_o
);

  localparam int c_off_w = line_off_w(LINE_WORDS);
  localparam int c_cnt_w = beat_cnt_w(LINE_WORDS);
  localparam logic [c_cnt_w-1:0] c_last_beat = c_cnt_w'(LINE_WORDS - 1);

  state_e                    state_q, state_d;
  logic                      winner_q, winner_d;
  logic                      last_grant_q, last_grant_d;
  logic                      flush_pend_q, flush_pend_d;
  logic [1:0]                served_q, served_d;
  logic [c_cnt_w-1:0]        cnt_q, cnt_d;
  logic [XLEN-1:0]           addr_q, addr_d;
  logic [XLEN-1:0]           raddr_q, raddr_d;
  logic [32*LINE_WORDS-1:0]  buf_q, buf_d;
  logic [32*LINE_WORDS-1:0]  rline_q, rline_d;

  logic [XLEN-1:0]           aligned0, aligned1;
  logic                      win;
  logic                      last_beat;
  logic                      unused_addr_bits;

  assign aligned0  = {miss_addr_i[XLEN-1:c_off_w], {c_off_w{1'b0}}};
  assign aligned1  = {miss_addr_i[2*XLEN-1:XLEN+c_off_w], {c_off_w{1'b0}}};
  assign last_beat = (cnt_q == c_last_beat);
  assign unused_addr_bits = ^{miss_addr_i[c_off_w-1:0], miss_addr_i[XLEN+c_off_w-1:XLEN]};

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= S_IDLE;
      winner_q     <= 1'b0;
      last_grant_q <= 1'b1;
      flush_pend_q <= 1'b0;
      served_q     <= 2'b00;
      cnt_q        <= '0;
      addr_q       <= '0;
      raddr_q      <= '0;
      buf_q        <= '0;
      rline_q      <= '0;
    end else begin
      state_q      <= state_d;
      winner_q     <= winner_d;
      last_grant_q <= last_grant_d;
      flush_pend_q <= flush_pend_d;
      served_q     <= served_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      raddr_q      <= raddr_d;
      buf_q        <= buf_d;
      rline_q      <= rline_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    winner_d     = winner_q;
    last_grant_d = last_grant_q;
    flush_pend_d = flush_pend_q;
    served_d     = served_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    raddr_d      = raddr_q;
    buf_d        = buf_q;
    rline_d      = rline_q;
    win          = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!flush_i && (|miss_req_i)) begin
          // Round-robin only matters when both ports are asking.
          win          = (miss_req_i == 2'b11) ? ~last_grant_q : miss_req_i[1];
          winner_d     = win;
          addr_d       = win ? aligned1 : aligned0;
          served_d     = win ? 2'b10 : 2'b01;
          if ((miss_req_i == 2'b11) && (aligned0 == aligned1)) begin
            served_d = 2'b11;
          end
          cnt_d        = '0;
          flush_pend_d = 1'b0;
          state_d      = S_REQUEST;
        end
      end

      S_REQUEST: begin
        if (flush_i) begin
          flush_pend_d = 1'b1;
        end
        if (mem_ack_i) begin
          state_d = (flush_i || flush_pend_q) ? S_DRAIN : S_COLLECT;
        end
      end

      S_COLLECT: begin
        if (mem_data_valid_i) begin
          buf_d[{cnt_q, 5'b0} +: 32] = mem_data_i;
          if (last_beat) begin
            if (flush_i) begin
              state_d = S_IDLE;
            end else begin
              rline_d = buf_d;
              raddr_d = addr_q;
              state_d = S_DELIVER;
            end
          end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = flush_i ? S_DRAIN : S_COLLECT;
          end
        end else if (flush_i) begin
          state_d = S_DRAIN;
        end
      end

      S_DELIVER: begin
        last_grant_d = winner_q;
        state_d      = S_IDLE;
      end

      S_DRAIN: begin
        if (mem_data_valid_i) begin
          if (last_beat) begin
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign mem_req_o      = (state_q == S_REQUEST);
  assign mem_addr_o     = addr_q;
  assign refill_valid_o = (state_q == S_DELIVER) ? served_q : 2'b00;
  assign refill_addr_o  = raddr_q;
  assign refill_line_o  = rline_q;
  assign busy_o         = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_fetch_refill_arbiter.sv
// ============================================================================
// Module  : tb_fetch_refill_arbiter
// Purpose : Directed self-checking bench for fetch_refill_arbiter.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_fetch_refill_arbiter;

  localparam int XLEN = 32;
  localparam int LW   = 4;

  logic            clk;
  logic            rst;
  logic [1:0]      miss_req;
  logic [2*XLEN-1:0] miss_addr;
  logic            flush;
  logic            mem_req;
  logic [XLEN-1:0] mem_addr;
  logic            mem_ack;
  logic            mem_dv;
  logic [31:0]     mem_data;
  logic [1:0]      refill_valid;
  logic [XLEN-1:0] refill_addr;
  logic [32*LW-1:0] refill_line;
  logic            busy;

  int checks = 0;
  int errors = 0;

  fetch_refill_arbiter #(.XLEN(XLEN), .LINE_WORDS(LW)) dut (
    .clock_i          (clk),
    .reset_i          (rst),
    .miss_req_i       (miss_req),
    .miss_addr_i      (miss_addr),
    .flush_i          (flush),
    .mem_req_o        (mem_req),
    .mem_addr_o       (mem_addr),
    .mem_ack_i        (mem_ack),
    .mem_data_valid_i (mem_dv),
    .mem_data_i       (mem_data),
    .refill_valid_o   (refill_valid),
    .refill_addr_o    (refill_addr),
    .refill_line_o    (refill_line),
    .busy_o           (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [31:0] d, input logic fl);
    mem_dv   = 1'b1;
    mem_data = d;
    flush    = fl;
    tick();
    mem_dv   = 1'b0;
    flush    = 1'b0;
  endtask

  // Called one cycle after the miss was sampled: REQUEST is current.
  task automatic do_fetch(input string tag, input logic [31:0] exp_addr,
                          input logic [1:0] exp_valid, input logic [31:0] base,
                          input logic drop_after_ack);
    chk({tag, "_mem_req"}, 128'(mem_req), 128'(1'b1));
    chk({tag, "_mem_addr"}, 128'(mem_addr), 128'(exp_addr));
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    if (drop_after_ack) miss_req = 2'b00;
    chk({tag, "_req_drop"}, 128'(mem_req), 128'(1'b0));
    for (int i = 0; i < LW; i++) beat(base + 32'(i), 1'b0);
    chk({tag, "_refill_valid"}, 128'(refill_valid), 128'(exp_valid));
    chk({tag, "_refill_addr"}, 128'(refill_addr), 128'(exp_addr));
    chk({tag, "_refill_line"}, 128'(refill_line),
        {base + 32'd3, base + 32'd2, base + 32'd1, base});
  endtask

  initial begin
    rst = 1'b1; miss_req = 2'b00; miss_addr = '0; flush = 1'b0;
    mem_ack = 1'b0; mem_dv = 1'b0; mem_data = '0;
    tick(); tick();
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_mem_req", 128'(mem_req), 128'(0));
    chk("rst_mem_addr", 128'(mem_addr), 128'(0));
    chk("rst_refill_valid", 128'(refill_valid), 128'(0));
    chk("rst_refill_line", 128'(refill_line), 128'(0));
    rst = 1'b0;
    tick();

    // Both miss, port 0 wins first after reset
    miss_req = 2'b11; miss_addr = {32'h0000_0300, 32'h0000_0200};
    tick();
    do_fetch("rr1", 32'h200, 2'b01, 32'h10, 1'b0);
    miss_req = 2'b10;
    tick();
    chk("rr1_idle", 128'(busy), 128'(0));
    tick();
    do_fetch("rr2", 32'h300, 2'b10, 32'h20, 1'b0);
    miss_req = 2'b11;
    tick();
    tick();
    do_fetch("rr3", 32'h200, 2'b01, 32'h30, 1'b0);
    miss_req = 2'b10;
    tick(); tick();
    do_fetch("rr4", 32'h300, 2'b10, 32'h40, 1'b0);
    miss_req = 2'b00;
    tick();

    // Single port-0 miss, unaligned address
    miss_req = 2'b01; miss_addr = {32'h0, 32'h0000_0104};
    tick();
    do_fetch("basic", 32'h100, 2'b01, 32'h1, 1'b0);
    chk("basic_line_const", 128'(refill_line), 128'h00000004_00000003_00000002_00000001);
    miss_req = 2'b00;
    tick();
    chk("basic_pulse_end", 128'(refill_valid), 128'(0));
    chk("basic_hold_line", 128'(refill_line), 128'h00000004_00000003_00000002_00000001);
    chk("basic_hold_addr", 128'(refill_addr), 128'(32'h100));

    // Same line from both ports: single fetch, both pulse
    miss_req = 2'b11; miss_addr = {32'h0000_0408, 32'h0000_0404};
    tick();
    do_fetch("same", 32'h400, 2'b11, 32'h50, 1'b0);
    miss_req = 2'b00;
    tick();
    chk("same_idle", 128'(busy), 128'(0));

    // Flush in IDLE suppresses latching
    miss_req = 2'b01; miss_addr = {32'h0, 32'h0000_0A00}; flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("idle_flush_busy", 128'(busy), 128'(0));
    tick();
    do_fetch("after_iflush", 32'hA00, 2'b01, 32'h60, 1'b1);
    tick();

    // Flush after two beats: drain remaining beats, no delivery
    miss_req = 2'b01; miss_addr = {32'h0, 32'h0000_0500};
    tick();
    mem_ack = 1'b1; tick(); mem_ack = 1'b0;
    beat(32'h71, 1'b0); beat(32'h72, 1'b0);
    flush = 1'b1; miss_req = 2'b00;
    tick();
    flush = 1'b0;
    chk("drain_busy", 128'(busy), 128'(1));
    beat(32'h73, 1'b0);
    chk("drain_busy3", 128'(busy), 128'(1));
    chk("drain_rv3", 128'(refill_valid), 128'(0));
    beat(32'h74, 1'b0);
    chk("drain_done", 128'(busy), 128'(0));
    chk("drain_rv4", 128'(refill_valid), 128'(0));
    chk("drain_line_held", 128'(refill_line), {32'h63, 32'h62, 32'h61, 32'h60});
    miss_req = 2'b01; miss_addr = {32'h0, 32'h0000_0600};
    tick();
    do_fetch("post_drain", 32'h600, 2'b01, 32'h80, 1'b1);
    tick();

    // Flush while mem_req pending, ack three cycles later
    miss_req = 2'b01; miss_addr = {32'h0, 32'h0000_0700};
    tick();
    flush = 1'b1; miss_req = 2'b00;
    tick();
    flush = 1'b0;
    chk("rflush_hold1", 128'(mem_req), 128'(1));
    tick(); tick();
    chk("rflush_hold3", 128'(mem_req), 128'(1));
    mem_ack = 1'b1; tick(); mem_ack = 1'b0;
    chk("rflush_dropped", 128'(mem_req), 128'(0));
    for (int i = 0; i < LW - 1; i++) beat(32'h90 + 32'(i), 1'b0);
    chk("rflush_busy", 128'(busy), 128'(1));
    beat(32'h93, 1'b0);
    chk("rflush_rv", 128'(refill_valid), 128'(0));
    chk("rflush_idle", 128'(busy), 128'(0));

    // Flush together with the last beat
    miss_req = 2'b01; miss_addr = {32'h0, 32'h0000_0800};
    tick();
    mem_ack = 1'b1; tick(); mem_ack = 1'b0;
    miss_req = 2'b00;
    beat(32'hA0, 1'b0); beat(32'hA1, 1'b0); beat(32'hA2, 1'b0);
    beat(32'hA3, 1'b1);
    chk("lastflush_rv", 128'(refill_valid), 128'(0));
    chk("lastflush_idle", 128'(busy), 128'(0));
    chk("lastflush_addr", 128'(refill_addr), 128'(32'h600));

    // Asynchronous reset mid-COLLECT
    miss_req = 2'b01; miss_addr = {32'h0, 32'h0000_0900};
    tick();
    mem_ack = 1'b1; tick(); mem_ack = 1'b0;
    miss_req = 2'b00;
    beat(32'hB0, 1'b0); beat(32'hB1, 1'b0);
    rst = 1'b1;
    #1;
    chk("arst_busy", 128'(busy), 128'(0));
    chk("arst_mem_addr", 128'(mem_addr), 128'(0));
    chk("arst_line", 128'(refill_line), 128'(0));
    chk("arst_addr", 128'(refill_addr), 128'(0));
    tick();
    rst = 1'b0;
    beat(32'hC0, 1'b0); beat(32'hC1, 1'b0);
    chk("stray_busy", 128'(busy), 128'(0));
    chk("stray_rv", 128'(refill_valid), 128'(0));
    chk("stray_line", 128'(refill_line), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fetch_refill_arbiter.md
FETCH_REFILL_ARBITER -- requirements
Module: fetch_refill_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 32, address width.
REQ-002 SHALL have parameter LINE_WORDS, default 4, number of 32-bit words per cache line (power of two, 2..16).
REQ-003 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous and active-high.
REQ-005 SHALL have port miss_req[2], input, 1 each, per-cache-port refill request, level, held until served.
REQ-006 SHALL have port miss_addr[2], input, XLEN each, miss address per cache port.
REQ-007 SHALL have port flush, input, 1, abort the current refill (pipeline redirect).
REQ-008 SHALL have port mem_req, output, 1, memory line-read request.
REQ-009 SHALL have port mem_addr, output, XLEN, line-aligned request address.
REQ-010 SHALL have port mem_ack, input, 1, memory accepted the request this cycle.
REQ-011 SHALL have port mem_data_valid, input, 1, one returned beat this cycle.
REQ-012 SHALL have port mem_data, input, 32, returned beat, ascending word order.
REQ-013 SHALL have port refill_valid[2], output, 1 each, one-cycle pulse: line ready for that cache port.
REQ-014 SHALL have port refill_addr, output, XLEN, line-aligned address of delivered line.
REQ-015 SHALL have port refill_line, output, 32*LINE_WORDS, delivered line, word 0 in the LSBs.
REQ-016 SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-017 SHALL implement FSM states IDLE, REQUEST, COLLECT, DELIVER, DRAIN.
REQ-018 IDLE: any miss_req high -> latch winner and aligned address (low log2(LINE_WORDS*4) bits zeroed) -> REQUEST next cycle.
REQ-019 Both requesting in IDLE: SHALL grant the port not granted last; last-grant register resets to 1, so port 0 wins first.
REQ-020 If the loser's aligned address equals the winner's, SHALL mark both as served (single fetch, both refill_valid pulse).
REQ-021 REQUEST: mem_req=1 and mem_addr stable until mem_ack sampled high -> COLLECT; mem_req SHALL drop the cycle after ack.
REQ-022 COLLECT: each mem_data_valid stores mem_data at beat counter index, counter increments; counter==LINE_WORDS-1 with valid -> DELIVER.
REQ-023 Beats SHALL be ignored outside COLLECT and DRAIN.
REQ-024 DELIVER: exactly one cycle, refill_valid[i]=1 for every marked port, refill_addr/refill_line valid; -> IDLE; last-grant updated to winner.
REQ-025 Latency: miss_req sampled at edge N -> mem_req high from cycle N+1; last beat at edge M -> refill_valid high in cycle M+1.
REQ-026 refill_line and refill_addr SHALL hold their last value outside DELIVER; refill_valid low outside DELIVER.
REQ-027 flush in IDLE: no effect; the same-cycle miss_req SHALL NOT be latched.
REQ-028 flush in REQUEST: mem_req held until mem_ack (no withdrawal), then DRAIN; flush together with mem_ack -> DRAIN directly.
REQ-029 flush in COLLECT: -> DRAIN, beat counter kept; DRAIN counts remaining beats without storing, last beat -> IDLE, no refill_valid.
REQ-030 flush coinciding with the last beat in COLLECT SHALL suppress delivery and go to IDLE.
REQ-031 flush in DELIVER SHALL NOT suppress the pulse (already committed).
REQ-032 flush in DRAIN: no additional effect.
REQ-033 A miss_req dropping while in service SHALL NOT abort the fetch; delivery still occurs.

Reset
REQ-034 SHALL on reset: state IDLE, mem_req 0, mem_addr 0, refill_valid 0/0, refill_addr 0, refill_line 0, beat counter 0, served marks 0, last-grant 1, busy 0.
REQ-035 Reset mid-COLLECT SHALL discard the partial line; beats arriving after reset release SHALL be ignored (IDLE).

Structure
REQ-036 SHALL place the FSM state enum and a line-offset-width function of LINE_WORDS in the shared package.
REQ-037 SHALL be one module; no sub-module required.

Verification
REQ-038 Port 0 miss 0x104 -> mem_addr 0x100 one cycle later; ack; beats 1,2,3,4 -> refill_valid[0] next cycle, refill_line 0x00000004_00000003_00000002_00000001.
REQ-039 Both miss, 0x200/0x300 -> port 0 served first (0x200), then port 1 (0x300); repeat -> port 0 first again because it did not win last.
REQ-040 Both miss 0x404/0x408 -> one mem_req at 0x400, both refill_valid pulse in same cycle.
REQ-041 flush after 2 of 4 beats -> busy until 4th beat, no refill_valid, then IDLE; next miss served normally.
REQ-042 flush while mem_req pending, ack 3 cycles later -> mem_req held until ack, 4 beats drained, no delivery.
REQ-043 reset asserted mid-COLLECT -> all outputs to reset values immediately; stray beats ignored.
